mem_write_checker: RTL and testbench

- Synthesizable successor to the per-test write checks and interrupt pulse stimulus used in the MIPS processor bench.
- Holds a programmable table of up to DEPTH expected (address, data) memory writes and checks the processor's memwrite/dataadr/writedata stream against it in order.
- Generates NIRQ one-shot interrupt pulses at programmed cycles, enforces a timeout, and reports pass/fail, cycle count and mismatch count.
- Sits beside `top` in the test harness; one instance per test run, re-armed with `start`.

---
 rtl/mem_write_checker.sv | 143 ++++++++++++++
 tb/tb_mem_write_checker.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// mem_write_checker: in-order checker of a processor's memory-write stream against a programmed table,
// with one-shot interrupt stimulus, a run timeout and pass/fail reporting.
module mem_write_checker #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int DEPTH   = 16,
   parameter int IW      = 4,
   parameter int NIRQ    = 8,
   parameter int CW      = 32,
   parameter int TIMEOUT = 1000
) (
   input  logic            ph1,
   input  logic            reset,
   input  logic            start,
   input  logic            exp_we,
   input  logic [IW-1:0]   exp_idx,
   input  logic [AW-1:0]   exp_addr,
   input  logic [DW-1:0]   exp_data,
   input  logic            irq_we,
   input  logic [2:0]      irq_idx,
   input  logic [CW-1:0]   irq_time,
   input  logic [NIRQ-1:0] irq_en,
   input  logic [IW:0]     num_exp,
   input  logic            check_addr,
   input  logic            strict,
   input  logic            memwrite,
   input  logic [AW-1:0]   dataadr,
   input  logic [DW-1:0]   writedata,
   output logic [NIRQ-1:0] interrupts,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic            timed_out,
   output logic [CW-1:0]   cycle_count,
   output logic [15:0]     mismatch_count,
   output logic [IW:0]     match_idx
);
   typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
   logic [AW-1:0] exp_addr_q [DEPTH];
   logic [DW-1:0] exp_data_q [DEPTH];
   logic [CW-1:0] irq_time_q [NIRQ];
   state_t state_q, state_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic [15:0] mis_q, mis_d;
   logic [IW:0] midx_q, midx_d, num_q, num_d;
   logic ca_q, ca_d, st_q, st_d, to_q, to_d;
   logic [NIRQ-1:0] irq_q, irq_d, fired_q, fired_d;
   logic [IW-1:0] idx;
   logic wr, hit, complete;

   always_comb begin
      idx = midx_q[IW-1:0];
      // once every entry has matched, further writes are not compared
      wr = memwrite && (midx_q != num_q);
      hit = (writedata == exp_data_q[idx]) && (!ca_q || dataadr == exp_addr_q[idx]);
      complete = (midx_q == num_q) || (wr && hit && (midx_q + (IW+1)'(1) == num_q));
      state_d = state_q;
      cyc_d = cyc_q;
      mis_d = mis_q;
      midx_d = midx_q;
      num_d = num_q;
      ca_d = ca_q;
      st_d = st_q;
      to_d = to_q;
      irq_d = '0;
      fired_d = fired_q;
      if (start) begin
         state_d = RUN;
         cyc_d = '0;
         mis_d = '0;
         midx_d = '0;
         to_d = 1'b0;
         fired_d = '0;
         num_d = (num_exp > (IW+1)'(DEPTH)) ? (IW+1)'(DEPTH) : num_exp;
         ca_d = check_addr;
         st_d = strict;
      end else if (state_q == RUN) begin
         cyc_d = &cyc_q ? cyc_q : cyc_q + CW'(1);
         if (wr && hit) midx_d = midx_q + (IW+1)'(1);
         if (wr && !hit) mis_d = &mis_q ? mis_q : mis_q + 16'd1;
         for (int i = 0; i < NIRQ; i++) begin
            irq_d[i] = irq_en[i] && !fired_q[i] && (cyc_q == irq_time_q[i]);
            fired_d[i] = fired_q[i] | irq_d[i];
         end
         if (complete) state_d = PASS;
         else begin
            if (wr && !hit && st_q) state_d = FAIL;
            if (cyc_q == CW'(TIMEOUT - 1)) begin
               state_d = FAIL;
               to_d = 1'b1;
            end
         end
         if (state_d != RUN) irq_d = '0;
      end
   end

   always_ff @(posedge ph1 or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cyc_q <= '0;
         mis_q <= '0;
         midx_q <= '0;
         num_q <= '0;
         ca_q <= 1'b0;
         st_q <= 1'b0;
         to_q <= 1'b0;
         irq_q <= '0;
         fired_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            exp_addr_q[k] <= '0;
            exp_data_q[k] <= '0;
         end
         for (int k = 0; k < NIRQ; k++) irq_time_q[k] <= '0;
      end else begin
         state_q <= state_d;
         cyc_q <= cyc_d;
         mis_q <= mis_d;
         midx_q <= midx_d;
         num_q <= num_d;
         ca_q <= ca_d;
         st_q <= st_d;
         to_q <= to_d;
         irq_q <= irq_d;
         fired_q <= fired_d;
         if (state_q != RUN) begin
            if (exp_we && {1'b0, exp_idx} < (IW+1)'(DEPTH)) begin
               exp_addr_q[exp_idx] <= exp_addr;
               exp_data_q[exp_idx] <= exp_data;
            end
            if (irq_we && {1'b0, irq_idx} < 4'(NIRQ)) irq_time_q[irq_idx] <= irq_time;
         end
      end
   end

   assign busy = state_q == RUN;
   assign done = (state_q == PASS) || (state_q == FAIL);
   assign pass = state_q == PASS;
   assign timed_out = to_q;
   assign cycle_count = cyc_q;
   assign mismatch_count = mis_q;
   assign match_idx = midx_q;
   assign interrupts = irq_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed checks of the write checker with hand-computed expectations.
module tb_mem_write_checker;
   logic        ph1 = 1'b0;
   logic        reset, start, exp_we, irq_we, check_addr, strict, memwrite;
   logic [3:0]  exp_idx;
   logic [31:0] exp_addr, exp_data, irq_time, dataadr, writedata, cycle_count;
   logic [2:0]  irq_idx;
   logic [7:0]  irq_en, interrupts;
   logic [4:0]  num_exp, match_idx;
   logic        busy, done, pass, timed_out;
   logic [15:0] mismatch_count;
   int checks = 0, errors = 0;
   int c0, c1, t0, t1;

   mem_write_checker dut (
      .ph1(ph1), .reset(reset), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
      .exp_addr(exp_addr), .exp_data(exp_data), .irq_we(irq_we), .irq_idx(irq_idx),
      .irq_time(irq_time), .irq_en(irq_en), .num_exp(num_exp), .check_addr(check_addr),
      .strict(strict), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .interrupts(interrupts), .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
      .cycle_count(cycle_count), .mismatch_count(mismatch_count), .match_idx(match_idx)
   );

   always #5 ph1 = ~ph1;

   task automatic step(input int n = 1);
      repeat (n) @(negedge ph1);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic count_irqs(input int n);
      for (int k = 0; k < n; k++) begin
         if (interrupts[0]) begin c0++; t0 = int'(cycle_count); end
         if (interrupts[1]) begin c1++; t1 = int'(cycle_count); end
         exp_we = (n == 60 && k == 55);
         exp_idx = 4'd0;
         exp_data = 32'd7;
         step();
      end
      exp_we = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 0; exp_we = 0; irq_we = 0; check_addr = 0; strict = 0; memwrite = 0;
      exp_idx = 0; exp_addr = 0; exp_data = 0; irq_time = 0; dataadr = 0; writedata = 0;
      irq_idx = 0; irq_en = 0; num_exp = 0;
      step(2);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cc", cycle_count, 0);
      chk("rst_irq", interrupts, 0);
      reset = 1'b0;
      exp_we = 1; exp_idx = 0; exp_addr = 32'h14; exp_data = 32'd21;
      step();
      exp_we = 0; num_exp = 1; check_addr = 1; start = 1;
      step();
      start = 0;
      chk("s1_busy", busy, 1);
      chk("s1_cc0", cycle_count, 0);
      step(40);
      chk("s1_cc40", cycle_count, 40);
      memwrite = 1; dataadr = 32'h14; writedata = 32'd21;
      step();
      memwrite = 0;
      chk("s1_pass", pass, 1);
      chk("s1_done", done, 1);
      chk("s1_midx", match_idx, 1);
      chk("s1_mis", mismatch_count, 0);
      chk("s1_cc41", cycle_count, 41);
      exp_we = 1; exp_idx = 0; exp_addr = 32'h0; exp_data = 32'd479001600;
      step();
      exp_we = 0; check_addr = 0; start = 1;
      step();
      start = 0; memwrite = 1; dataadr = 32'h7ffc; writedata = 32'd5;
      step();
      chk("s2_mis", mismatch_count, 1);
      chk("s2_busy", busy, 1);
      chk("s2_midx0", match_idx, 0);
      dataadr = 32'h7ff8; writedata = 32'd479001600;
      step();
      memwrite = 0;
      chk("s2_pass", pass, 1);
      chk("s2_midx1", match_idx, 1);
      strict = 1; start = 1;
      step();
      start = 0; memwrite = 1; dataadr = 32'h7ffc; writedata = 32'd5;
      step();
      chk("s3_done", done, 1);
      chk("s3_pass", pass, 0);
      chk("s3_to", timed_out, 0);
      chk("s3_mis", mismatch_count, 1);
      dataadr = 32'h7ff8; writedata = 32'd479001600;
      step();
      memwrite = 0;
      chk("s3_sticky_midx", match_idx, 0);
      chk("s3_sticky_pass", pass, 0);
      strict = 0; num_exp = 2; start = 1;
      step();
      start = 0;
      step(999);
      chk("s4_cc999", cycle_count, 999);
      chk("s4_busy", busy, 1);
      step();
      chk("s4_done", done, 1);
      chk("s4_pass", pass, 0);
      chk("s4_to", timed_out, 1);
      chk("s4_cc1000", cycle_count, 1000);
      step();
      chk("s4_cc_hold", cycle_count, 1000);
      irq_we = 1; irq_idx = 0; irq_time = 50;
      step();
      irq_idx = 1; irq_time = 20;
      step();
      irq_we = 0; irq_en = 8'h03; num_exp = 1; check_addr = 0; start = 1;
      step();
      start = 0;
      c0 = 0; c1 = 0; t0 = 0; t1 = 0;
      count_irqs(30);
      chk("s5_c1", c1, 1);
      chk("s5_t1", t1, 21);
      chk("s5_c0", c0, 0);
      start = 1;
      step();
      start = 0;
      chk("s5_restart_irq", interrupts, 0);
      chk("s5_restart_cc", cycle_count, 0);
      c0 = 0; c1 = 0; t0 = 0; t1 = 0;
      count_irqs(60);
      chk("s5_rearm_c1", c1, 1);
      chk("s5_rearm_t1", t1, 21);
      chk("s5_c0b", c0, 1);
      chk("s5_t0", t0, 51);
      memwrite = 1; writedata = 32'd479001600;
      step();
      memwrite = 0;
      chk("s5_table_kept", pass, 1);
      chk("s5_irq_off", interrupts, 0);
      irq_en = 0; num_exp = 1; start = 1;
      step();
      start = 0;
      step(5);
      reset = 1;
      #1;
      chk("s6_rst_busy", busy, 0);
      chk("s6_rst_cc", cycle_count, 0);
      chk("s6_rst_done", done, 0);
      step(2);
      reset = 0; num_exp = 0; start = 1;
      step();
      start = 0;
      chk("s6_busy", busy, 1);
      chk("s6_done0", done, 0);
      step();
      chk("s6_pass", pass, 1);
      chk("s6_midx", match_idx, 0);
      chk("s6_cc", cycle_count, 1);
      num_exp = 17; check_addr = 1; start = 1;
      step();
      start = 0; memwrite = 1; dataadr = 0; writedata = 0;
      step(15);
      chk("s7_midx15", match_idx, 15);
      chk("s7_busy", busy, 1);
      step();
      memwrite = 0;
      chk("s7_clamp_pass", pass, 1);
      chk("s7_midx16", match_idx, 16);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
